// File: rtl/clock_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// The output mode is derived from the active ratio and selects the clk_out source.
package clock_div_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BYPASS = 2'd1,
        MODE_EVEN   = 2'd2,
        MODE_ODD    = 2'd3
    } out_mode_e;

    // Length of the high phase in rising-edge cycles: ceil(d/2).
    function automatic logic [3:0] half_ratio(input logic [3:0] d);
        logic [4:0] sum;
        sum = {1'b0, d} + 5'd1;
        return sum[4:1];
    endfunction

    function automatic out_mode_e mode_of(input logic [3:0] d);
        if (d == 4'd0)
            return MODE_OFF;
        else if (d == 4'd1)
            return MODE_BYPASS;
        else if (d[0])
            return MODE_ODD;
        else
            return MODE_EVEN;
    endfunction

endpackage

// File: rtl/clock_div_core.sv
// Phase counter and the two phase registers of the divider.
// The ratio is latched only at a period boundary so every period completes at the old ratio.
//
// state        | meaning
// -------------+--------------------------------------------------
// div_q <= 1   | disabled or bypass: reload div on every rising edge
// cnt < H      | high phase (pos_q set)
// cnt >= H     | low phase (pos_q clear)
// cnt == N-1   | last cycle of the period: reload div_q, restart high
module clock_div_core
    import clock_div_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst,
    input  logic [3:0] div,
    output logic [3:0] div_q,
    output logic       pos_q,
    output logic       neg_q
);

    logic [3:0] cnt;
    logic [4:0] cnt_inc;
    logic       boundary;

    assign cnt_inc  = {1'b0, cnt} + 5'd1;
    assign boundary = (div_q <= 4'd1) || (cnt == div_q - 4'd1);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            div_q <= 4'd0;
            cnt   <= 4'd0;
            pos_q <= 1'b0;
        end else if (boundary) begin
            div_q <= div;
            cnt   <= 4'd0;
            pos_q <= (div >= 4'd2);
        end else begin
            cnt   <= cnt_inc[3:0];
            pos_q <= (cnt_inc < {1'b0, half_ratio(div_q)});
        end
    end

    // Half-cycle delayed copy; ANDed with pos_q it moves odd-ratio rises onto a falling edge.
    always_ff @(negedge clk_in or posedge rst) begin
        if (rst)
            neg_q <= 1'b0;
        else
            neg_q <= pos_q;
    end

endmodule

// File: rtl/clock_div.sv
// Programmable integer clock divider, ratio 0..15, 50 % duty for all ratios >= 1.
// Top level holds the output source select, including the ratio-1 bypass and reset gating.
module clock_div
    import clock_div_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst,
    input  logic [3:0] div,
    output logic       clk_out
);

    logic [3:0] div_q;
    logic       pos_q;
    logic       neg_q;

    clock_div_core u_core (
        .clk_in (clk_in),
        .rst    (rst),
        .div    (div),
        .div_q  (div_q),
        .pos_q  (pos_q),
        .neg_q  (neg_q)
    );

    // Sources only change on a rising edge of clk_in, where all candidates agree or rise.
    always_comb begin
        clk_out = 1'b0;
        case (mode_of(div_q))
            MODE_BYPASS: clk_out = clk_in;
            MODE_EVEN:   clk_out = pos_q;
            MODE_ODD:    clk_out = pos_q & neg_q;
            default:     clk_out = 1'b0;
        endcase
        if (rst)
            clk_out = 1'b0;
    end

endmodule

// File: tb/tb_clock_div.sv
// Directed bench for clock_div: clk_out is sampled 1 ns after every rising and falling
// edge of clk_in and compared against hand-written waveform strings.
module tb_clock_div;

    logic       clk_in;
    logic       rst;
    logic [3:0] div;
    logic       clk_out;

    int n_cmp = 0;
    int n_err = 0;

    clock_div dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .div     (div),
        .clk_out (clk_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic chk(input string tag, input logic exp);
        n_cmp++;
        assert (clk_out === exp) else begin
            n_err++;
            $error("FAIL %s: clk_out=%b expected %b at %0t", tag, clk_out, exp, $time);
        end
    endtask

    // Each pair of characters is one clk_in cycle: sample after rise, sample after fall.
    task automatic chk_pat(input string tag, input string pat);
        for (int i = 0; i < pat.len() / 2; i++) begin
            @(posedge clk_in);
            #1;
            chk(tag, pat[2*i] == 8'd49);
            @(negedge clk_in);
            #1;
            chk(tag, pat[2*i+1] == 8'd49);
        end
    endtask

    initial begin
        rst = 1'b1;
        div = 4'd1;

        // 100 ns of reset: output held low even though div=1 requests bypass
        chk_pat("reset", "00000000000000000000");
        rst = 1'b0;

        // bypass from the first rising edge after release
        chk_pat("div1_release", "1010101010");

        div = 4'd2;
        chk_pat("div2", "1100110011001100");

        div = 4'd4;
        chk_pat("div4", "1111000011110000");

        // change 4->8 two cycles into a period: the 40 ns period finishes first
        chk_pat("div4_head", "1111");
        div = 4'd8;
        chk_pat("div4_tail", "0000");
        chk_pat("div8", "11111111000000001111111100000000");

        div = 4'd3;
        chk_pat("div3", "011100011100011100");

        div = 4'd5;
        chk_pat("div5", "01111100000111110000");

        div = 4'd1;
        chk_pat("div5_to_1", "101010");

        div = 4'd4;
        chk_pat("div1_to_4", "11110000");

        div = 4'd0;
        chk_pat("div0", "0000000000");

        // reset in the middle of a high phase
        div = 4'd2;
        @(posedge clk_in);
        #1;
        chk("pre_rst_high", 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_high", 1'b0);
        @(negedge clk_in);
        #1;
        chk("rst_held", 1'b0);
        rst = 1'b0;
        chk_pat("restart_div2", "11001100");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
